// File: rtl/keypad_debounce_encoder.sv
// -----------------------------------------------------------------------------
// keypad_debounce_encoder
//
// Keypad front end for the microwave control path. The raw one-hot key lines
// pass through a two-flop synchroniser and a priority encoder. Presses and
// releases are then debounced by a small FSM. Each accepted press produces a
// one-cycle `valid` strobe together with a level `held` flag.
//
// Optional feature: define KEYPAD_AUTOREPEAT_EN to enable auto-repeat strobes
// while a key stays pressed. REPEAT_DELAY and REPEAT_PERIOD have no effect
// when the macro is undefined.
//
// Parameters:
//   N_KEYS        number of key lines (2..31)
//   CODE_W        code width, 2**CODE_W > N_KEYS
//   DEBOUNCE      stable cycles needed to accept a press or a release (>=1)
//   REPEAT_DELAY  hold cycles before the first repeat strobe
//   REPEAT_PERIOD cycles between later repeat strobes
//
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   enable  in   block enable; low clears the FSM and outputs synchronously
//   keys    in   raw key lines, active high, asynchronous to clk
//   code    out  accepted key code (keys[N_KEYS-1] -> 0 ... keys[0] -> N_KEYS-1),
//                all ones when no key is accepted
//   valid   out  one-cycle strobe for a newly accepted press (or a repeat)
//   held    out  high while the accepted key remains debounced-pressed
//   multi   out  high while the synchronised bus has more than one bit set
// -----------------------------------------------------------------------------
module keypad_debounce_encoder #(
    parameter int N_KEYS        = 10,
    parameter int CODE_W        = 4,
    parameter int DEBOUNCE      = 3,
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [N_KEYS-1:0] keys,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    output logic              held,
    output logic              multi
);

    localparam int                CNT_W     = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE - 1);
    localparam logic [CODE_W-1:0] CODE_NONE = {CODE_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        PRESSED    = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    // Synchroniser stages
    logic [N_KEYS-1:0] r_ks_p0;
    logic [N_KEYS-1:0] r_ks_p1;

    logic [CODE_W-1:0] w_cand;
    logic              w_multi_nxt;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [CODE_W-1:0] r_lat;
    logic [CODE_W-1:0] w_lat_nxt;
    logic [CODE_W-1:0] r_code;
    logic [CODE_W-1:0] w_code_nxt;
    logic              r_valid;
    logic              w_valid_nxt;
    logic              r_held;
    logic              w_held_nxt;
    logic              r_multi;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int               REP_MAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                            : REPEAT_PERIOD;
    localparam int               REP_W     = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_PERIOD);

    logic [REP_W-1:0] r_rep_cnt;
    logic [REP_W-1:0] w_rep_cnt_nxt;
    logic [REP_W-1:0] w_rep_inc;
    logic             r_rep_first;
    logic             w_rep_first_nxt;

    assign w_rep_inc = r_rep_cnt + REP_W'(1);
`else
    logic [1:0] w_unused_rep_cfg;
    assign w_unused_rep_cfg = {REPEAT_DELAY[0], REPEAT_PERIOD[0]};
`endif

    // -------------------------------------------------------------------------
    // Stage p0/p1: two-flop synchroniser. It keeps running while enable is low.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ks_p0 <= '0;
            r_ks_p1 <= '0;
        end else begin
            r_ks_p0 <= keys;
            r_ks_p1 <= r_ks_p0;
        end
    end

    // Priority encode: the ascending scan lets the highest set index win.
    always_comb begin
        w_cand = CODE_NONE;
        for (int i = 0; i < N_KEYS; i++) begin
            if (r_ks_p1[i]) begin
                w_cand = CODE_W'(N_KEYS - 1 - i);
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign w_multi_nxt = |(r_ks_p1 & (r_ks_p1 - N_KEYS'(1)));

    // -------------------------------------------------------------------------
    // Stage p2: debounce FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (!enable) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_cand != CODE_NONE) w_state_nxt = PRESS_DB;
                end
                PRESS_DB: begin
                    if (w_cand == CODE_NONE) begin
                        w_state_nxt = IDLE;
                    end else if (w_cand == r_lat && r_cnt == CNT_LAST) begin
                        w_state_nxt = PRESSED;
                    end
                end
                PRESSED: begin
                    // Any change of the encoded key, including a higher-priority
                    // key joining, counts as a release of the latched key.
                    if (w_cand != r_lat) w_state_nxt = RELEASE_DB;
                end
                RELEASE_DB: begin
                    if (w_cand == r_lat) begin
                        w_state_nxt = PRESSED;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Output and datapath next values
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_lat_nxt   = r_lat;
        w_code_nxt  = r_code;
        w_valid_nxt = 1'b0;
        w_held_nxt  = r_held;
`ifdef KEYPAD_AUTOREPEAT_EN
        w_rep_cnt_nxt   = r_rep_cnt;
        w_rep_first_nxt = r_rep_first;
`endif
        if (!enable) begin
            w_cnt_nxt  = '0;
            w_lat_nxt  = CODE_NONE;
            w_code_nxt = CODE_NONE;
            w_held_nxt = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            w_rep_cnt_nxt   = '0;
            w_rep_first_nxt = 1'b1;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_cand != CODE_NONE) begin
                        w_lat_nxt = w_cand;
                        w_cnt_nxt = '0;
                    end
                end
                PRESS_DB: begin
                    if (w_cand == CODE_NONE) begin
                        w_cnt_nxt = '0;
                    end else if (w_cand != r_lat) begin
                        w_lat_nxt = w_cand;
                        w_cnt_nxt = '0;
                    end else if (r_cnt == CNT_LAST) begin
                        w_cnt_nxt   = '0;
                        w_code_nxt  = r_lat;
                        w_valid_nxt = 1'b1;
                        w_held_nxt  = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                        w_rep_cnt_nxt   = '0;
                        w_rep_first_nxt = 1'b1;
`endif
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (w_cand != r_lat) begin
                        w_cnt_nxt = '0;
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    else if ((r_rep_first && w_rep_inc == REP_FIRST) ||
                             (!r_rep_first && w_rep_inc == REP_NEXT)) begin
                        w_valid_nxt     = 1'b1;
                        w_rep_cnt_nxt   = '0;
                        w_rep_first_nxt = 1'b0;
                    end else begin
                        w_rep_cnt_nxt = w_rep_inc;
                    end
`endif
                end
                RELEASE_DB: begin
                    // A return to the latched key is a glitch; the repeat
                    // counter simply holds across it.
                    if (w_cand != r_lat) begin
                        if (r_cnt == CNT_LAST) begin
                            w_cnt_nxt  = '0;
                            w_held_nxt = 1'b0;
                            w_code_nxt = CODE_NONE;
`ifdef KEYPAD_AUTOREPEAT_EN
                            w_rep_cnt_nxt   = '0;
                            w_rep_first_nxt = 1'b1;
`endif
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    w_cnt_nxt = '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Stage p2: registered outputs and debounce datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_lat   <= CODE_NONE;
            r_code  <= CODE_NONE;
            r_valid <= 1'b0;
            r_held  <= 1'b0;
            r_multi <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
`endif
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_lat   <= w_lat_nxt;
            r_code  <= w_code_nxt;
            r_valid <= w_valid_nxt;
            r_held  <= w_held_nxt;
            r_multi <= enable & w_multi_nxt;
`ifdef KEYPAD_AUTOREPEAT_EN
            r_rep_cnt   <= w_rep_cnt_nxt;
            r_rep_first <= w_rep_first_nxt;
`endif
        end
    end

    assign code  = r_code;
    assign valid = r_valid;
    assign held  = r_held;
    assign multi = r_multi;

endmodule

// File: tb/tb_keypad_debounce_encoder.sv
module tb_keypad_debounce_encoder;

    localparam int NK   = 10;
    localparam int CW   = 4;
    localparam int DB   = 3;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam bit AR   = 1'b1;
    localparam int RD   = 20;
    localparam int RP   = 8;
`else
    localparam bit AR   = 1'b0;
    localparam int RD   = 500;
    localparam int RP   = 100;
`endif
    localparam int NONE = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [NK-1:0] keys;
    logic [CW-1:0] code;
    logic          valid;
    logic          held;
    logic          multi;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [NK-1:0] k;
        logic          en;
        int            c;
        int            v;
        int            h;
        int            m;
    } vec_t;

    vec_t tab[$];

    // Reference model state
    logic [NK-1:0] m_s1, m_s2;
    bit            m_held;
    int            m_run, m_miss, m_rlat, m_since;
    int            e_code, e_valid, e_held, e_multi;

    keypad_debounce_encoder #(
        .N_KEYS(NK), .CODE_W(CW), .DEBOUNCE(DB),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .keys(keys),
        .code(code), .valid(valid), .held(held), .multi(multi)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [NK-1:0] k);
        rst_n  = 1'b0;
        enable = 1'b1;
        keys   = k;
        repeat (3) tick();
        check("rst_code",  int'(code),  NONE);
        check("rst_valid", int'(valid), 0);
        check("rst_held",  int'(held),  0);
        check("rst_multi", int'(multi), 0);
        rst_n = 1'b1;
    endtask

    task automatic add(input logic [NK-1:0] k, input logic en, input int c,
                       input int v, input int h, input int m, input int n);
        vec_t r;
        r.k = k; r.en = en; r.c = c; r.v = v; r.h = h; r.m = m;
        for (int i = 0; i < n; i++) tab.push_back(r);
    endtask

    function automatic int enc(input logic [NK-1:0] v);
        for (int i = NK - 1; i >= 0; i--) begin
            if (v[i]) return NK - 1 - i;
        end
        return NONE;
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_held = 1'b0;
        m_run = 0; m_miss = 0; m_rlat = NONE; m_since = 0;
        e_code = NONE; e_valid = 0; e_held = 0; e_multi = 0;
    endtask

    // One clock edge: the FSM sees the key bus from two edges earlier.
    // A press is accepted after DB+1 consecutive edges of the same key,
    // a release after DB+1 consecutive edges without the held key.
    task automatic model_edge(input logic [NK-1:0] k, input logic en);
        logic [NK-1:0] ks_now;
        int c;
        ks_now = m_s2;
        m_s2   = m_s1;
        m_s1   = k;
        c      = enc(ks_now);
        e_valid = 0;
        if (!en) begin
            m_held = 1'b0; m_run = 0; m_miss = 0; m_since = 0;
            e_code = NONE; e_held = 0; e_multi = 0;
        end else begin
            e_multi = ($countones(ks_now) > 1) ? 1 : 0;
            if (!m_held) begin
                if (c == NONE) m_run = 0;
                else if (m_run > 0 && c == m_rlat) m_run++;
                else begin m_rlat = c; m_run = 1; end
                if (m_run == DB + 1) begin
                    m_held = 1'b1; e_code = c; e_valid = 1; e_held = 1;
                    m_run = 0; m_miss = 0; m_since = 0;
                end
            end else if (c == e_code) begin
                if (AR && m_miss == 0) begin
                    m_since++;
                    if (m_since == RD || (m_since > RD && (m_since - RD) % RP == 0))
                        e_valid = 1;
                end
                m_miss = 0;
            end else begin
                m_miss++;
                if (m_miss == DB + 1) begin
                    m_held = 1'b0; e_held = 0; e_code = NONE; m_miss = 0;
                end
            end
        end
    endtask

    initial begin
        logic [NK-1:0] pat;
        logic          en_r;
        int            seg;

        // Table: press 0x200 from reset, release, 0x041 multi-key press, enable drop
        add(10'h200, 1'b1, NONE, 0, 0, 0, 5);
        add(10'h200, 1'b1, 0,    1, 1, 0, 1);
        add(10'h200, 1'b1, 0,    0, 1, 0, 2);
        add(10'h000, 1'b1, 0,    0, 1, 0, 5);
        add(10'h000, 1'b1, NONE, 0, 0, 0, 1);
        add(10'h041, 1'b1, NONE, 0, 0, 0, 2);
        add(10'h041, 1'b1, NONE, 0, 0, 1, 3);
        add(10'h041, 1'b1, 3,    1, 1, 1, 1);
        add(10'h041, 1'b1, 3,    0, 1, 1, 2);
        add(10'h041, 1'b0, NONE, 0, 0, 0, 1);
        add(10'h041, 1'b1, NONE, 0, 0, 1, 3);
        add(10'h041, 1'b1, 3,    1, 1, 1, 1);
        add(10'h041, 1'b1, 3,    0, 1, 1, 1);

        do_reset(10'h200);
        foreach (tab[i]) begin
            keys   = tab[i].k;
            enable = tab[i].en;
            tick();
            check("tab_code",  int'(code),  tab[i].c);
            check("tab_valid", int'(valid), tab[i].v);
            check("tab_held",  int'(held),  tab[i].h);
            check("tab_multi", int'(multi), tab[i].m);
        end

        // Bouncing key 0x001, then stable from edge 8
        do_reset('0);
        for (int e = 0; e < 16; e++) begin
            keys = (e < 8 && (e % 2) == 1) ? 10'h000 : 10'h001;
            tick();
            check("bounce_valid", int'(valid), (e == 13) ? 1 : 0);
            if (e == 13) check("bounce_code", int'(code), 9);
        end

        // Held 0x010 with a one-cycle dropout, then full release
        do_reset('0);
        for (int e = 0; e < 28; e++) begin
            keys = (e == 10 || e >= 21) ? 10'h000 : 10'h010;
            tick();
            if (e == 5) begin
                check("drop_accept_valid", int'(valid), 1);
                check("drop_accept_code",  int'(code),  5);
            end
            if (e >= 6 && e <= 25) begin
                check("drop_held",  int'(held),  1);
                check("drop_valid", int'(valid), 0);
                check("drop_code",  int'(code),  5);
            end
            if (e == 26) begin
                check("release_held", int'(held), 0);
                check("release_code", int'(code), NONE);
            end
        end

        // Reset asserted in the middle of press debounce
        do_reset('0);
        keys = 10'h200;
        for (int e = 0; e < 4; e++) begin
            tick();
            check("pre_rst_valid", int'(valid), 0);
        end
        rst_n = 1'b0;
        #1;
        check("async_rst_code", int'(code), NONE);
        check("async_rst_held", int'(held), 0);
        tick();
        tick();
        check("in_rst_valid", int'(valid), 0);
        rst_n = 1'b1;
        for (int e = 0; e < 8; e++) begin
            tick();
            check("restart_valid", int'(valid), (e == 5) ? 1 : 0);
            if (e == 5) check("restart_code", int'(code), 0);
        end

        // Long hold: one strobe, plus repeats only in the auto-repeat build
        do_reset('0);
        for (int e = 0; e < 66; e++) begin
            keys = (e < 50) ? 10'h200 : 10'h000;
            tick();
            check("hold_valid", int'(valid),
                  ((e == 5) || (AR && e >= RD + 5 && e <= 49 && ((e - RD - 5) % RP) == 0)) ? 1 : 0);
        end

        // Randomised segments against the reference model
        do_reset('0);
        model_reset();
        seg  = 0;
        pat  = '0;
        en_r = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (seg == 0) begin
                seg = int'($urandom_range(1, 12));
                case ($urandom_range(0, 5))
                    0, 1:    pat = '0;
                    2, 3:    pat = NK'(1) << $urandom_range(0, NK - 1);
                    4:       pat = (NK'(1) << $urandom_range(0, NK - 1)) |
                                   (NK'(1) << $urandom_range(0, NK - 1));
                    default: pat = NK'($urandom);
                endcase
                en_r = ($urandom_range(0, 19) != 0);
            end
            seg--;
            keys   = pat;
            enable = en_r;
            tick();
            model_edge(pat, en_r);
            check("rnd_code",  int'(code),  e_code);
            check("rnd_valid", int'(valid), e_valid);
            check("rnd_held",  int'(held),  e_held);
            check("rnd_multi", int'(multi), e_multi);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
